// File: rtl/clahe_div_pkg.sv
// Shared definitions for the tagged pipelined divider: default widths,
// the per-stage payload layout, the all-ones quotient constant and the
// latency helper.
// Optional feature macro: CLAHE_DIV_ROUND_EN (adds a round-half-up output stage).
package clahe_div_pkg;

    // Default configuration. Each module re-declares these as overridable parameters.
    localparam int CLAHE_DIV_DVD_W = 32;
    localparam int CLAHE_DIV_DVS_W = 32;
    localparam int CLAHE_DIV_BPS   = 1;
    localparam int CLAHE_DIV_TAG_W = 8;

    // Quotient reported for a zero divisor, and the rounding saturation value.
    localparam logic [CLAHE_DIV_DVD_W-1:0] CLAHE_DIV_QUOT_ONES = '1;

    // Payload carried by every pipeline stage, shown at the default widths.
    // The stage module keeps the same fields at its own parameter widths.
    // The remainder held between stages needs only DIVISOR_W bits: the
    // extra working bit exists only inside a stage's compare step.
    typedef struct packed {
        logic [CLAHE_DIV_DVS_W-1:0] rem;
        logic [CLAHE_DIV_DVD_W-1:0] quot;
        logic [CLAHE_DIV_DVD_W-1:0] dvd_rest;
        logic [CLAHE_DIV_DVS_W-1:0] dvs;
        logic [CLAHE_DIV_TAG_W-1:0] tag;
        logic                       div0;
        logic                       valid;
    } clahe_div_payload_t;

    // Cycles from acceptance to result: one stage per BITS_PER_STAGE
    // quotient bits, plus the rounding stage when it is built.
    function automatic int clahe_div_lat(input int dividend_w,
                                         input int bits_per_stage,
                                         input bit round_en);
        return dividend_w / bits_per_stage + (round_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/clahe_div_pipe_tagged_stage.sv
// One pipeline stage of the restoring divider: BITS_PER_STAGE unrolled
// shift-compare-subtract steps followed by the stage register, which loads
// only when the whole pipeline advances.
module clahe_div_stage
    import clahe_div_pkg::*;
#(
    parameter int DIVIDEND_W     = CLAHE_DIV_DVD_W,
    parameter int DIVISOR_W      = CLAHE_DIV_DVS_W,
    parameter int BITS_PER_STAGE = CLAHE_DIV_BPS,
    parameter int TAG_W          = CLAHE_DIV_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  prev_valid,
    input  logic [DIVISOR_W-1:0]  prev_rem,
    input  logic [DIVIDEND_W-1:0] prev_quot,
    input  logic [DIVIDEND_W-1:0] prev_dvd_rest,
    input  logic [DIVISOR_W-1:0]  prev_dvs,
    input  logic [TAG_W-1:0]      prev_tag,
    input  logic                  prev_div0,
    output logic                  valid,
    output logic [DIVISOR_W-1:0]  rem,
    output logic [DIVIDEND_W-1:0] quot,
    output logic [DIVIDEND_W-1:0] dvd_rest,
    output logic [DIVISOR_W-1:0]  dvs,
    output logic [TAG_W-1:0]      tag,
    output logic                  div0
);

    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W-1:0]  rem_next;
    logic [DIVIDEND_W-1:0] quot_next;
    logic [DIVIDEND_W-1:0] dvd_next;

    logic                  valid_reg;
    logic [DIVISOR_W-1:0]  rem_reg;
    logic [DIVIDEND_W-1:0] quot_reg;
    logic [DIVIDEND_W-1:0] dvd_rest_reg;
    logic [DIVISOR_W-1:0]  dvs_reg;
    logic [TAG_W-1:0]      tag_reg;
    logic                  div0_reg;

    // Restoring division steps, dividend bits consumed MSB first. The shifted
    // partial remainder is DIVISOR_W+1 bits wide; after a subtract the result
    // always fits back into DIVISOR_W bits. A zero divisor needs no special
    // case: every step subtracts, so the quotient fills with ones and the
    // remainder ends up holding the dividend's low DIVISOR_W bits.
    always_comb begin
        shifted   = '0;
        rem_next  = prev_rem;
        quot_next = prev_quot;
        dvd_next  = prev_dvd_rest;
        for (int s = 0; s < BITS_PER_STAGE; s++) begin
            shifted  = {rem_next, dvd_next[DIVIDEND_W-1]};
            dvd_next = dvd_next << 1;
            if (shifted >= {1'b0, prev_dvs}) begin
                rem_next  = shifted[DIVISOR_W-1:0] - prev_dvs;
                quot_next = {quot_next[DIVIDEND_W-2:0], 1'b1};
            end else begin
                rem_next  = shifted[DIVISOR_W-1:0];
                quot_next = {quot_next[DIVIDEND_W-2:0], 1'b0};
            end
        end
    end

    // Stage register: loads on advance, holds on stall, clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= 1'b0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            dvd_rest_reg <= '0;
            dvs_reg      <= '0;
            tag_reg      <= '0;
            div0_reg     <= 1'b0;
        end else if (advance) begin
            valid_reg    <= prev_valid;
            rem_reg      <= rem_next;
            quot_reg     <= quot_next;
            dvd_rest_reg <= dvd_next;
            dvs_reg      <= prev_dvs;
            tag_reg      <= prev_tag;
            div0_reg     <= prev_div0;
        end
    end

    assign valid    = valid_reg;
    assign rem      = rem_reg;
    assign quot     = quot_reg;
    assign dvd_rest = dvd_rest_reg;
    assign dvs      = dvs_reg;
    assign tag      = tag_reg;
    assign div0     = div0_reg;

endmodule

// File: rtl/clahe_div_pipe_tagged.sv
// Fully pipelined tagged unsigned divider with valid/ready flow control.
// The whole pipeline shifts together whenever the output slot is free or
// being consumed; tags travel alongside their operands so results come out
// in acceptance order with their tag attached.
// Optional feature macro: CLAHE_DIV_ROUND_EN (round-half-up output stage,
// one extra cycle of latency, quotient saturates at all ones).
module clahe_div_pipe_tagged
    import clahe_div_pkg::*;
#(
    parameter int DIVIDEND_W     = CLAHE_DIV_DVD_W,
    parameter int DIVISOR_W      = CLAHE_DIV_DVS_W,
    parameter int BITS_PER_STAGE = CLAHE_DIV_BPS,
    parameter int TAG_W          = CLAHE_DIV_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] in_dividend,
    input  logic [DIVISOR_W-1:0]  in_divisor,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] out_quotient,
    output logic [DIVISOR_W-1:0]  out_remainder,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_div0
);

    // Number of divider stages equals the latency of the truncating build.
    localparam int N = clahe_div_lat(DIVIDEND_W, BITS_PER_STAGE, 1'b0);

    logic advance;

    // Index 0 is the operand input; index i+1 is the register of stage i.
    logic                  st_valid [0:N];
    logic [DIVISOR_W-1:0]  st_rem   [0:N];
    logic [DIVIDEND_W-1:0] st_quot  [0:N];
    logic [DIVIDEND_W-1:0] st_dvd   [0:N];
    logic [DIVISOR_W-1:0]  st_dvs   [0:N];
    logic [TAG_W-1:0]      st_tag   [0:N];
    logic                  st_div0  [0:N];

    // A stalled output slot is the only thing that can hold the pipeline.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign st_valid[0] = in_valid;
    assign st_rem[0]   = '0;
    assign st_quot[0]  = '0;
    assign st_dvd[0]   = in_dividend;
    assign st_dvs[0]   = in_divisor;
    assign st_tag[0]   = in_tag;
    assign st_div0[0]  = (in_divisor == '0);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            clahe_div_stage #(
                .DIVIDEND_W     (DIVIDEND_W),
                .DIVISOR_W      (DIVISOR_W),
                .BITS_PER_STAGE (BITS_PER_STAGE),
                .TAG_W          (TAG_W)
            ) u_stage (
                .clk           (clk),
                .rst_n         (rst_n),
                .advance       (advance),
                .prev_valid    (st_valid[gi]),
                .prev_rem      (st_rem[gi]),
                .prev_quot     (st_quot[gi]),
                .prev_dvd_rest (st_dvd[gi]),
                .prev_dvs      (st_dvs[gi]),
                .prev_tag      (st_tag[gi]),
                .prev_div0     (st_div0[gi]),
                .valid         (st_valid[gi+1]),
                .rem           (st_rem[gi+1]),
                .quot          (st_quot[gi+1]),
                .dvd_rest      (st_dvd[gi+1]),
                .dvs           (st_dvs[gi+1]),
                .tag           (st_tag[gi+1]),
                .div0          (st_div0[gi+1])
            );
        end
    endgenerate

`ifdef CLAHE_DIV_ROUND_EN
    logic                  round_up;
    logic [DIVIDEND_W-1:0] rnd_quot_next;

    logic                  rnd_valid_reg;
    logic [DIVIDEND_W-1:0] rnd_quot_reg;
    logic [DIVISOR_W-1:0]  rnd_rem_reg;
    logic [TAG_W-1:0]      rnd_tag_reg;
    logic                  rnd_div0_reg;

    // Round half up: bump the quotient when 2*rem >= divisor, saturating at
    // all ones. Divide-by-zero results pass through untouched.
    always_comb begin
        round_up      = !st_div0[N] && ({st_rem[N], 1'b0} >= {1'b0, st_dvs[N]});
        rnd_quot_next = st_quot[N];
        if (round_up && (st_quot[N] != '1)) begin
            rnd_quot_next = st_quot[N] + 1'b1;
        end
    end

    // Rounding output register, in step with the divider stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_valid_reg <= 1'b0;
            rnd_quot_reg  <= '0;
            rnd_rem_reg   <= '0;
            rnd_tag_reg   <= '0;
            rnd_div0_reg  <= 1'b0;
        end else if (advance) begin
            rnd_valid_reg <= st_valid[N];
            rnd_quot_reg  <= rnd_quot_next;
            rnd_rem_reg   <= st_rem[N];
            rnd_tag_reg   <= st_tag[N];
            rnd_div0_reg  <= st_div0[N];
        end
    end

    assign out_valid     = rnd_valid_reg;
    assign out_quotient  = rnd_quot_reg;
    assign out_remainder = rnd_rem_reg;
    assign out_tag       = rnd_tag_reg;
    assign out_div0      = rnd_div0_reg;
`else
    // Truncating build: the last divider stage drives the outputs directly.
    assign out_valid     = st_valid[N];
    assign out_quotient  = st_quot[N];
    assign out_remainder = st_rem[N];
    assign out_tag       = st_tag[N];
    assign out_div0      = st_div0[N];
`endif

endmodule

// File: tb/tb_clahe_div_pipe_tagged.sv
// Self-checking bench for clahe_div_pipe_tagged: directed vector table,
// mid-flight reset, randomized stream under output back-pressure, and three
// 16/12-bit instances with 1, 2 and 4 bits per stage fed the same stream.
// Honors CLAHE_DIV_ROUND_EN when the design is built with it.
module tb_clahe_div_pipe_tagged;

`ifdef CLAHE_DIV_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int DW       = 32;
    localparam int VW       = 32;
    localparam int LAT_MAIN = DW + (RND ? 1 : 0);
    localparam int SDW      = 16;
    localparam int SVW      = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_dividend = '0;
    logic [VW-1:0] in_divisor = '0;
    logic [7:0]    in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_quotient;
    logic [VW-1:0] out_remainder;
    logic [7:0]    out_tag;
    logic          out_div0;

    logic           s_valid = 1'b0;
    logic [SDW-1:0] s_dvd = '0;
    logic [SVW-1:0] s_dvs = '0;
    logic [7:0]     s_tag = '0;
    logic           s_in_ready  [3];
    logic           s_out_valid [3];
    logic [SDW-1:0] s_q         [3];
    logic [SVW-1:0] s_r         [3];
    logic [7:0]     s_otag      [3];
    logic           s_div0      [3];

    always #5 clk = ~clk;

    clahe_div_pipe_tagged u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_tag       (out_tag),
        .out_div0      (out_div0)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_small
            clahe_div_pipe_tagged #(
                .DIVIDEND_W     (SDW),
                .DIVISOR_W      (SVW),
                .BITS_PER_STAGE (1 << gi),
                .TAG_W          (8)
            ) u_small (
                .clk           (clk),
                .rst_n         (rst_n),
                .in_valid      (s_valid),
                .in_ready      (s_in_ready[gi]),
                .in_dividend   (s_dvd),
                .in_divisor    (s_dvs),
                .in_tag        (s_tag),
                .out_valid     (s_out_valid[gi]),
                .out_ready     (1'b1),
                .out_quotient  (s_q[gi]),
                .out_remainder (s_r[gi]),
                .out_tag       (s_otag[gi]),
                .out_div0      (s_div0[gi])
            );
        end
    endgenerate

    typedef struct {
        longint unsigned q;
        longint unsigned r;
        bit              div0;
    } res_t;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic [7:0]    tag;
        bit            div0;
        int            acc;
        bit            chk_lat;
    } exp_t;

    typedef struct {
        logic [DW-1:0] dvd;
        logic [VW-1:0] dvs;
        logic [7:0]    tag;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        bit            div0;
    } vec_t;

    typedef struct {
        logic [SDW-1:0] q;
        logic [SVW-1:0] r;
        logic [7:0]     tag;
        bit             div0;
        int             acc;
    } sitem_t;

    int     n_checks = 0;
    int     n_pass = 0;
    int     cyc = 0;
    exp_t   sb[$];
    sitem_t s_items[$];
    int     rd_idx [3];
    exp_t   cur_exp;
    bit     acc_flag = 1'b0;
    bit     stall_prev = 1'b0;
    bit     rdy_mode = 1'b0;
    int     lo_run = 0;
    int     n_rx_main = 0;
    logic [DW-1:0] held_q;
    logic [VW-1:0] held_r;
    logic [7:0]    held_tag;
    logic          held_div0;
    vec_t   vecs[9];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference divider from the arithmetic definition.
    function automatic res_t ref_div(input longint unsigned dvd, input longint unsigned dvs,
                                     input int dvd_w, input int dvs_w);
        res_t            res;
        longint unsigned qmax;
        qmax = (64'd1 << dvd_w) - 64'd1;
        if (dvs == 0) begin
            res.q    = qmax;
            res.r    = dvd & ((64'd1 << dvs_w) - 64'd1);
            res.div0 = 1'b1;
        end else begin
            res.q    = dvd / dvs;
            res.r    = dvd % dvs;
            res.div0 = 1'b0;
            if (RND && (2 * res.r >= dvs) && (res.q != qmax)) res.q = res.q + 1;
        end
        return res;
    endfunction

    function automatic logic [31:0] rand_dvs();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 32'd0;
        if (sel == 1) return 32'd1;
        return $urandom >> $urandom_range(0, 31);
    endfunction

    task automatic set_rand_main(input logic [7:0] tag);
        res_t res;
        in_dividend = $urandom;
        in_divisor  = rand_dvs();
        in_tag      = tag;
        res = ref_div(64'(in_dividend), 64'(in_divisor), DW, VW);
        cur_exp.q       = res.q[DW-1:0];
        cur_exp.r       = res.r[VW-1:0];
        cur_exp.tag     = tag;
        cur_exp.div0    = res.div0;
        cur_exp.acc     = 0;
        cur_exp.chk_lat = 1'b0;
    endtask

    // One clock: drive back-pressure, sample at negedge, score both benches.
    task automatic cycle();
        exp_t   e;
        sitem_t si;
        res_t   res;
        if (rdy_mode) begin
            if (lo_run > 0) begin
                out_ready = 1'b0;
                lo_run--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        check("in_ready_is_advance", 64'(in_ready), 64'(!out_valid || out_ready));
        if (stall_prev) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_quot", 64'(out_quotient), 64'(held_q));
            check("stall_rem", 64'(out_remainder), 64'(held_r));
            check("stall_tag", 64'(out_tag), 64'(held_tag));
            check("stall_div0", 64'(out_div0), 64'(held_div0));
        end
        acc_flag = in_valid && in_ready;
        if (acc_flag) begin
            e = cur_exp;
            e.acc = cyc;
            sb.push_back(e);
        end
        if (out_valid && out_ready) begin
            check("result_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("rx tag=%02h q=%08h r=%08h div0=%0b", out_tag, out_quotient, out_remainder, out_div0);
                check("quotient", 64'(out_quotient), 64'(e.q));
                check("remainder", 64'(out_remainder), 64'(e.r));
                check("tag", 64'(out_tag), 64'(e.tag));
                check("div0", 64'(out_div0), 64'(e.div0));
                if (e.chk_lat) check("latency", 64'(cyc - e.acc), 64'(LAT_MAIN));
                n_rx_main++;
            end
        end
        stall_prev = out_valid && !out_ready;
        held_q    = out_quotient;
        held_r    = out_remainder;
        held_tag  = out_tag;
        held_div0 = out_div0;

        if (s_valid) begin
            res = ref_div(64'(s_dvd), 64'(s_dvs), SDW, SVW);
            si.q    = res.q[SDW-1:0];
            si.r    = res.r[SVW-1:0];
            si.tag  = s_tag;
            si.div0 = res.div0;
            si.acc  = cyc;
            s_items.push_back(si);
        end
        for (int k = 0; k < 3; k++) begin
            check("s_in_ready", 64'(s_in_ready[k]), 64'd1);
            if (s_out_valid[k]) begin
                check("s_result_expected", 64'(rd_idx[k] < s_items.size()), 64'd1);
                if (rd_idx[k] < s_items.size()) begin
                    si = s_items[rd_idx[k]];
                    check("s_quotient", 64'(s_q[k]), 64'(si.q));
                    check("s_remainder", 64'(s_r[k]), 64'(si.r));
                    check("s_tag", 64'(s_otag[k]), 64'(si.tag));
                    check("s_div0", 64'(s_div0[k]), 64'(si.div0));
                    check("s_latency", 64'(cyc - si.acc), 64'((SDW >> k) + (RND ? 1 : 0)));
                    rd_idx[k]++;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_main(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        check("main_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'd100,        32'd10, 8'h01, 32'd10,                  32'd0, 1'b0};
        vecs[1] = '{32'd255,        32'd3,  8'h02, 32'd85,                  32'd0, 1'b0};
        vecs[2] = '{32'd0,          32'd10, 8'h03, 32'd0,                   32'd0, 1'b0};
        vecs[3] = '{32'd7,          32'd0,  8'h5A, 32'hFFFF_FFFF,           32'd7, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF,  32'd1,  8'h04, 32'hFFFF_FFFF,           32'd0, 1'b0};
        vecs[5] = '{32'd5,          32'd9,  8'h05, (RND ? 32'd1  : 32'd0),  32'd5, 1'b0};
        vecs[6] = '{32'd100,        32'd8,  8'h06, (RND ? 32'd13 : 32'd12), 32'd4, 1'b0};
        vecs[7] = '{32'd99,         32'd10, 8'h07, (RND ? 32'd10 : 32'd9),  32'd9, 1'b0};
        vecs[8] = '{32'd200,        32'd7,  8'h08, (RND ? 32'd29 : 32'd28), 32'd4, 1'b0};
        for (int k = 0; k < 3; k++) rd_idx[k] = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_quotient", 64'(out_quotient), 64'd0);
        check("rst_out_remainder", 64'(out_remainder), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_div0", 64'(out_div0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready_after_release", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed table, back-to-back with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid    = 1'b1;
            in_dividend = vecs[i].dvd;
            in_divisor  = vecs[i].dvs;
            in_tag      = vecs[i].tag;
            cur_exp = '{vecs[i].q, vecs[i].r, vecs[i].tag, vecs[i].div0, 0, 1'b1};
            cycle();
        end
        in_valid = 1'b0;
        drain_main(200);

        // Reset with ten transactions in flight.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            set_rand_main(8'(8'hA0 + i));
            cycle();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        check("midrst_out_quotient", 64'(out_quotient), 64'd0);
        sb.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            check("post_rst_quiet", 64'(out_valid), 64'd0);
        end
        in_valid    = 1'b1;
        in_dividend = 32'd200;
        in_divisor  = 32'd7;
        in_tag      = 8'h33;
        cur_exp = '{(RND ? 32'd29 : 32'd28), 32'd4, 8'h33, 1'b0, 0, 1'b1};
        cycle();
        in_valid = 1'b0;
        n_rx_main = 0;
        drain_main(200);
        check("post_rst_result_count", 64'(n_rx_main), 64'd1);

        // Random stream with toggling out_ready and a 40-cycle stall.
        n_rx_main = 0;
        rdy_mode = 1'b1;
        for (int i = 0; i < 64; i++) begin
            int guard;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                cycle();
            end
            if (i == 10) lo_run = 40;
            in_valid = 1'b1;
            set_rand_main(8'(i));
            guard = 0;
            acc_flag = 1'b0;
            while (!acc_flag && guard < 500) begin
                cycle();
                guard++;
            end
            check("producer_accepted", 64'(acc_flag), 64'd1);
        end
        in_valid = 1'b0;
        drain_main(3000);
        rdy_mode = 1'b0;
        out_ready = 1'b1;
        check("random_result_count", 64'(n_rx_main), 64'd64);

        // Same random stream shape into 16/12-bit instances, 1/2/4 bits per stage.
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                s_valid = 1'b0;
                cycle();
            end
            s_valid = 1'b1;
            s_dvd   = 16'($urandom);
            s_dvs   = 12'(rand_dvs());
            s_tag   = 8'(i);
            cycle();
        end
        s_valid = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (rd_idx[0] >= 64 && rd_idx[1] >= 64 && rd_idx[2] >= 64) break;
            cycle();
        end
        for (int k = 0; k < 3; k++) check("s_result_count", 64'(rd_idx[k]), 64'd64);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
